// File: rtl/ether_firewall.sv
// Receive-path MAC filter: checks the destination (and optionally the ethertype) of a
// dibit-serial Ethernet frame, strips the 14-byte header and forwards payload dibits only.
module ether_firewall #(
  parameter logic [47:0] MY_MAC     = 48'h69_69_5A_06_54_91,
  parameter bit          CHECK_TYPE = 1'b0,
  parameter logic [15:0] ETHERTYPE  = 16'h0800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEST = 3'd1,
    SRC  = 3'd2,
    TYPE = 3'd3,
    PASS = 3'd4,
    DROP = 3'd5
  } state_t;

  localparam logic [5:0] LAST_DEST = 6'd23;
  localparam logic [5:0] LAST_SRC  = 6'd47;
  localparam logic [5:0] LAST_TYPE = 6'd55;
  localparam logic [5:0] CNT_SAT   = 6'd56;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       mac_miss_q, mac_miss_d;
  logic       bcast_miss_q, bcast_miss_d;
  logic       type_miss_q, type_miss_d;
  logic       axiov_q, axiov_d;
  logic [1:0] axiod_q, axiod_d;

  // Expected dibit per header position; padded to 32 so any 5-bit index is legal.
  logic [1:0] mac_tbl  [32];
  logic [1:0] type_tbl [8];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mac_tbl
      if (gi < 24) begin : g_used
        assign mac_tbl[gi] = MY_MAC[47-2*gi -: 2];
      end else begin : g_pad
        assign mac_tbl[gi] = 2'b00;
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_type_tbl
      assign type_tbl[gi] = ETHERTYPE[15-2*gi -: 2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      mac_miss_q   <= 1'b0;
      bcast_miss_q <= 1'b0;
      type_miss_q  <= 1'b0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mac_miss_q   <= mac_miss_d;
      bcast_miss_q <= bcast_miss_d;
      type_miss_q  <= type_miss_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mac_miss_d   = mac_miss_q;
    bcast_miss_d = bcast_miss_q;
    type_miss_d  = type_miss_q;
    if (!axiiv) begin
      state_d      = IDLE;
      cnt_d        = 6'd0;
      mac_miss_d   = 1'b0;
      bcast_miss_d = 1'b0;
      type_miss_d  = 1'b0;
    end else begin
      cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 6'd1;
      case (state_q)
        // IDLE shares the DEST path so dibit 0 is evaluated on the first valid cycle.
        IDLE, DEST: begin
          mac_miss_d   = mac_miss_q | (axiid != mac_tbl[cnt_q[4:0]]);
          bcast_miss_d = bcast_miss_q | (axiid != 2'b11);
          if (cnt_q == LAST_DEST) begin
            state_d = (mac_miss_d && bcast_miss_d) ? DROP : SRC;
          end else begin
            state_d = DEST;
          end
        end
        SRC: begin
          if (cnt_q == LAST_SRC) state_d = TYPE;
        end
        TYPE: begin
          type_miss_d = type_miss_q | (CHECK_TYPE && (axiid != type_tbl[cnt_q[2:0]]));
          if (cnt_q == LAST_TYPE) state_d = type_miss_d ? DROP : PASS;
        end
        PASS, DROP: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    axiov_d = (state_q == PASS) && axiiv;
    axiod_d = axiov_d ? axiid : 2'b00;
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;

endmodule

// File: tb/tb_ether_firewall.sv
// Bench for ether_firewall: directed and random frames checked cycle by cycle against a
// frame-level model (accept decision from header bytes, payload echoed one cycle later).
module tb_ether_firewall;

  localparam logic [47:0] MY    = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       ov0, ov1;
  logic [1:0] od0, od1;

  int tests = 0;
  int fails = 0;
  logic [7:0] fb[$];

  always #10 clk = ~clk;

  ether_firewall #(.MY_MAC(MY), .CHECK_TYPE(1'b0), .ETHERTYPE(16'h0800)) dut0 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(ov0), .axiod(od0));
  ether_firewall #(.MY_MAC(MY), .CHECK_TYPE(1'b1), .ETHERTYPE(16'h0800)) dut1 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(ov1), .axiod(od1));

  task automatic chk(input int obs, input int exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dib(input int k);
    logic [7:0] b;
    b = fb[k/4];
    return 2'(b >> (6 - 2*(k%4)));
  endfunction

  task automatic mk_hdr(input logic [47:0] dst, input logic [15:0] typ);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(8'(dst >> (40 - 8*i)));
    for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
    fb.push_back(typ[15:8]);
    fb.push_back(typ[7:0]);
  endtask

  // Accept decision from whole header bytes; only meaningful for frames >= 14 bytes.
  task automatic model(output bit a0, output bit a1);
    logic [47:0] dst;
    logic [15:0] typ;
    dst = '0;
    typ = '0;
    for (int i = 0; i < 6 && i < fb.size(); i++) dst = {dst[39:0], fb[i]};
    if (fb.size() >= 14) typ = {fb[12], fb[13]};
    a0 = (fb.size() >= 14) && (dst == MY || dst == BCAST);
    a1 = a0 && (typ == 16'h0800);
  endtask

  task automatic chk_dibit(input int j, input bit a0, input bit a1, input int rst_at,
                           input string name, inout int hi0, inout int hi1);
    bit live, e0, e1;
    live = (j >= 56) && !(rst_at >= 0 && j >= rst_at);
    e0 = a0 && live;
    e1 = a1 && live;
    chk({ov0, od0}, {e0, e0 ? dib(j) : 2'b00}, $sformatf("%s dut0 dibit%0d", name, j));
    chk({ov1, od1}, {e1, e1 ? dib(j) : 2'b00}, $sformatf("%s dut1 dibit%0d", name, j));
    hi0 += int'(ov0);
    hi1 += int'(ov1);
  endtask

  task automatic run_frame(input int rst_at, input int gap, input string name,
                           output int hi0, output int hi1);
    bit a0, a1;
    int ndib;
    ndib = fb.size() * 4;
    hi0 = 0;
    hi1 = 0;
    model(a0, a1);
    for (int k = 0; k < ndib; k++) begin
      @(negedge clk);
      if (k > 0) chk_dibit(k - 1, a0, a1, rst_at, name, hi0, hi1);
      axiiv = 1'b1;
      axiid = dib(k);
      rst   = (k == rst_at);
    end
    @(negedge clk);
    if (ndib > 0) chk_dibit(ndib - 1, a0, a1, rst_at, name, hi0, hi1);
    axiiv = 1'b0;
    axiid = 2'b00;
    rst   = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk({ov0, od0, ov1, od1}, 0, $sformatf("%s gap%0d", name, g));
    end
    $display("[TB] frame %s: %0d dibits accept=%0d/%0d out=%0d/%0d",
             name, ndib, a0, a1, hi0, hi1);
  endtask

  initial begin
    int h0, h1, sel, nb;
    logic [47:0] dst;
    logic [15:0] typ;

    // Reset dominates even with a live input stream.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst   = 1'b1;
      axiiv = 1'b1;
      axiid = 2'($urandom);
      if (i > 0) chk({ov0, od0, ov1, od1}, 0, $sformatf("reset%0d", i));
    end
    @(negedge clk);
    chk({ov0, od0, ov1, od1}, 0, "reset_final");
    rst   = 1'b0;
    axiiv = 1'b0;
    @(negedge clk);
    chk({ov0, od0, ov1, od1}, 0, "post_reset_idle");

    mk_hdr(MY, 16'h0800);
    fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);
    run_frame(-1, 1, "unicast", h0, h1);
    chk(h0, 16, "unicast_len0");
    chk(h1, 16, "unicast_len1");

    mk_hdr(BCAST, 16'h0800);
    fb.push_back(8'h12); fb.push_back(8'h34);
    run_frame(-1, 1, "bcast", h0, h1);
    chk(h0, 8, "bcast_len");

    mk_hdr(48'h69_69_5A_06_54_90, 16'h0800);
    repeat (4) fb.push_back(8'($urandom));
    run_frame(-1, 1, "lastbit", h0, h1);
    chk(h0, 0, "lastbit_len");

    mk_hdr(MY, 16'h0800);
    repeat (4) fb.push_back(8'($urandom));
    run_frame(-1, 1, "after_drop", h0, h1);
    chk(h0, 16, "after_drop_len");

    mk_hdr(MY, 16'h0800);
    while (fb.size() > 10) void'(fb.pop_back());
    run_frame(-1, 1, "runt40", h0, h1);
    chk(h0, 0, "runt_len");

    mk_hdr(MY, 16'h0800);
    repeat (2) fb.push_back(8'($urandom));
    run_frame(-1, 1, "after_runt", h0, h1);
    chk(h0, 8, "after_runt_len");

    mk_hdr(MY, 16'h86DD);
    repeat (4) fb.push_back(8'($urandom));
    run_frame(-1, 1, "ipv6", h0, h1);
    chk(h0, 16, "ipv6_len0");
    chk(h1, 0, "ipv6_len1");

    mk_hdr(MY, 16'h0800);
    fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);
    run_frame(61, 1, "rst_mid", h0, h1);
    chk(h0, 5, "rst_mid_len");

    mk_hdr(MY, 16'h0800);
    repeat (3) fb.push_back(8'($urandom));
    run_frame(-1, 1, "after_rst", h0, h1);
    chk(h0, 12, "after_rst_len");

    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: dst = MY;
        1: dst = BCAST;
        2: dst = MY ^ (48'h1 << $urandom_range(0, 47));
        default: dst = {$urandom, 16'($urandom)};
      endcase
      typ = ($urandom_range(0, 1) == 0) ? 16'h0800 : 16'($urandom);
      mk_hdr(dst, typ);
      nb = $urandom_range(0, 20);
      repeat (nb) fb.push_back(8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        nb = $urandom_range(1, 13);
        while (fb.size() > nb) void'(fb.pop_back());
      end
      run_frame(-1, $urandom_range(1, 3), $sformatf("rand%0d", f), h0, h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
